// File: rtl/rr_arb4_139.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rr_arb4_139 : 4-way round-robin arbiter with hold limit and 139 decode   |
// | Revision    : 1.0                                                        |
// +------------------------------------------------------------------------+
module rr_arb4_139 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       G_L,
  input  logic [3:0] REQ_L,
  output logic [3:0] GNT_L,
  output logic [1:0] SEL,
  output logic       BUSY
);

  localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] C_HC_MAX = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] C_HC_ONE = HC_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [HC_W-1:0] hc_q, hc_d;

  logic [3:0] w_req;
  logic [7:0] w_req2;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic       w_pick_valid;
  logic [1:0] w_pick_idx;
  logic       w_owner_req;
  logic       w_others_pend;
  logic       w_rel;

  assign w_req  = ~REQ_L;
  assign w_req2 = {w_req, w_req};
  // Rotate so that bit 0 is the requester currently holding top priority.
  assign w_rot  = w_req2[ptr_q +: 4];

  always_comb begin
    w_off        = 2'd0;
    w_pick_valid = 1'b1;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else if (w_rot[3]) w_off = 2'd3;
    else               w_pick_valid = 1'b0;
  end

  assign w_pick_idx    = ptr_q + w_off;
  assign w_owner_req   = w_req[sel_q];
  assign w_others_pend = |(w_req & ~(4'b0001 << sel_q));
  assign w_rel         = !w_owner_req || G_L || ((hc_q == C_HC_MAX) && w_others_pend);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
      hc_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hc_q    <= hc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hc_d    = hc_q;
    case (state_q)
      ST_IDLE: begin
        if (!G_L && w_pick_valid) begin
          state_d = ST_GRANT;
          sel_d   = w_pick_idx;
          hc_d    = C_HC_ONE;
        end
      end
      ST_GRANT: begin
        // All release causes collapse into one release, so PTR moves once.
        if (w_rel) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q + 2'd1;
          hc_d    = '0;
        end else if (hc_q != C_HC_MAX) begin
          hc_d = hc_q + C_HC_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign BUSY = (state_q == ST_GRANT);
  assign SEL  = sel_q;

  // 74x139 half: enable G = ~BUSY, B = SEL[1], A = SEL[0].
  always_comb begin
    GNT_L = 4'b1111;
    if (BUSY) begin
      case (sel_q)
        2'd0:    GNT_L = 4'b1110;
        2'd1:    GNT_L = 4'b1101;
        2'd2:    GNT_L = 4'b1011;
        default: GNT_L = 4'b0111;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb4_139.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_rr_arb4_139 : directed self-checking bench for rr_arb4_139            |
// | Revision       : 1.0                                                     |
// +------------------------------------------------------------------------+
module tb_rr_arb4_139;

  logic       clk;
  logic       rst;
  logic       g_l;
  logic [3:0] req_l;
  logic [3:0] gnt_l;
  logic [1:0] sel;
  logic       busy;

  int checks;
  int failures;

  rr_arb4_139 #(.MAX_HOLD(8)) dut (
    .CLK  (clk),
    .RESET(rst),
    .G_L  (g_l),
    .REQ_L(req_l),
    .GNT_L(gnt_l),
    .SEL  (sel),
    .BUSY (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    g_l   = 1'b1;
    req_l = 4'b1111;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt",  32'(gnt_l), 32'hF);
    chk("rst_sel",  32'(sel), 32'd0);
    chk("rst_ptr",  32'(dut.ptr_q), 32'd0);
    rst = 1'b0;

    // First arbitration: everyone requesting, PTR=0 picks requester 0.
    g_l   = 1'b0;
    req_l = 4'b0000;
    step();
    chk("first_gnt",  32'(gnt_l), 32'hE);
    chk("first_sel",  32'(sel), 32'd0);
    chk("first_busy", 32'(busy), 32'd1);

    // Rotation 0,1,2,3,0 with the owner dropping one cycle into its grant.
    for (int k = 0; k < 4; k++) begin
      req_l = 4'b0001 << k;
      step();
      chk("rot_idle_busy", 32'(busy), 32'd0);
      chk("rot_idle_gnt",  32'(gnt_l), 32'hF);
      req_l = 4'b0000;
      step();
      chk("rot_gnt", 32'(gnt_l), 32'(~(4'b0001 << ((k + 1) % 4)) & 4'hF));
    end
    req_l = 4'b1111;
    step();
    chk("rot_end_busy", 32'(busy), 32'd0);
    chk("rot_end_ptr",  32'(dut.ptr_q), 32'd1);

    // Hold limit: reset between edges, then requesters 0 and 1 compete.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    req_l = 4'b1100;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("hold_gnt0", 32'(gnt_l), 32'hE);
    end
    chk("hold_hc", 32'(dut.hc_q), 32'd8);
    step();
    chk("hold_rel_busy", 32'(busy), 32'd0);
    chk("hold_rel_gnt",  32'(gnt_l), 32'hF);
    chk("hold_rel_ptr",  32'(dut.ptr_q), 32'd1);
    step();
    chk("hold_next_gnt", 32'(gnt_l), 32'hD);

    // Lone requester 2: grant persists and HC saturates.
    req_l = 4'b1011;
    step();
    chk("solo_idle", 32'(busy), 32'd0);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("solo_gnt2", 32'(gnt_l), 32'hB);
    end
    chk("solo_hc_sat", 32'(dut.hc_q), 32'd8);
    req_l = 4'b1111;
    step();
    chk("solo_rel_ptr", 32'(dut.ptr_q), 32'd3);

    // Enable withdrawn during grant of requester 1.
    req_l = 4'b1101;
    step();
    chk("gl_gnt1", 32'(gnt_l), 32'hD);
    g_l = 1'b1;
    step();
    chk("gl_gnt",  32'(gnt_l), 32'hF);
    chk("gl_busy", 32'(busy), 32'd0);
    chk("gl_ptr",  32'(dut.ptr_q), 32'd2);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("gl_hold_off", 32'(busy), 32'd0);
    end

    // Asynchronous reset mid-grant.
    g_l = 1'b0;
    step();
    chk("ar_gnt1", 32'(gnt_l), 32'hD);
    #2 rst = 1'b1;
    #1;
    chk("ar_gnt_now",  32'(gnt_l), 32'hF);
    chk("ar_busy_now", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    req_l = 4'b0101;
    step();
    chk("ar_after_gnt", 32'(gnt_l), 32'hD);
    chk("ar_after_sel", 32'(sel), 32'd1);

    // Owner drop and G_L=1 together: single release, PTR advances once.
    g_l   = 1'b1;
    req_l = 4'b0111;
    step();
    chk("dual_rel_busy", 32'(busy), 32'd0);
    chk("dual_rel_ptr",  32'(dut.ptr_q), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arb4_139.md
RR_ARB4_139 -- requirements
Module: rr_arb4_139

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles before a forced release while other requesters wait; legal range 2..255.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 G_L  input  1  active-low arbiter enable; 1 = no grants issued, current grant withdrawn.
REQ-005 REQ_L  input  4  active-low requests; bit i = requester i.
REQ-006 GNT_L  output  4  active-low one-hot grant, decoded from SEL exactly as a 74x139 2-to-4 decoder (B=SEL[1], A=SEL[0]).
REQ-007 SEL  output  2  registered index of current owner; valid only while BUSY=1.
REQ-008 BUSY  output  1  high while a grant is active.

Function
REQ-009 The block SHALL be a two-state FSM: IDLE and GRANT; all outputs SHALL be registered or decoded from registered state only.
REQ-010 GNT_L SHALL be 4'b1111 whenever BUSY=0, and SHALL have exactly one low bit, at index SEL, whenever BUSY=1.
REQ-011 A rotating pointer PTR (2 bits) SHALL hold the highest-priority index; priority order PTR, PTR+1, PTR+2, PTR+3 mod 4.
REQ-012 IDLE, G_L=0, any REQ_L bit low at edge: SHALL load SEL with the first requesting index in priority order, set BUSY=1, load hold counter HC=1, enter GRANT (grant visible 1 cycle after request sampled).
REQ-013 IDLE, G_L=1 or REQ_L=4'b1111: SHALL remain IDLE, outputs unchanged.
REQ-014 GRANT, owner's REQ_L[SEL]=1 at edge: SHALL release -- BUSY=0, GNT_L=4'b1111, PTR=SEL+1 mod 4, enter IDLE.
REQ-015 GRANT, G_L=1 at edge: SHALL release as in REQ-014 (PTR=SEL+1).
REQ-016 GRANT, owner still requesting, HC=MAX_HOLD and any other REQ_L bit low: SHALL force release as in REQ-014.
REQ-017 GRANT, owner still requesting, no other request pending: grant SHALL persist; HC SHALL saturate at MAX_HOLD, never wrap.
REQ-018 GRANT otherwise: HC SHALL increment by 1; SEL, BUSY unchanged.
REQ-019 Simultaneous release causes (owner drop, G_L=1, hold expiry) in one cycle SHALL produce a single release; PTR advances exactly once.
REQ-020 After any release the block SHALL spend exactly one cycle in IDLE before the next grant (no back-to-back grant without gap).
REQ-021 PTR SHALL wrap 3 -> 0; PTR SHALL change only on release.
REQ-022 HC width SHALL be ceil(log2(MAX_HOLD+1)) bits.
REQ-023 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration; no request latching.

Reset
REQ-024 RESET=1 SHALL immediately (asynchronously) force IDLE, BUSY=0, GNT_L=4'b1111, SEL=2'b00, PTR=2'b00, HC=0.
REQ-025 Reset asserted mid-grant SHALL drop GNT_L without waiting for a clock edge.
REQ-026 First arbitration after RESET deassertion SHALL use PTR=0.

Verification
REQ-027 Reset, G_L=0, REQ_L=4'b0000 -> one cycle later GNT_L=4'b1110, SEL=0, BUSY=1.
REQ-028 All four requesting continuously, each releasing on grant+1 cycle -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-029 MAX_HOLD=8, REQ_L=4'b1100 held -> requester 0 granted 8 cycles, forced release, 1 idle cycle, then GNT_L=4'b1101.
REQ-030 Only requester 2 requesting for 20 cycles -> GNT_L=4'b1011 held throughout, HC saturates at 8, no release.
REQ-031 G_L raised to 1 during grant of requester 1 -> next edge GNT_L=4'b1111, BUSY=0, PTR=2; no grant while G_L=1.
REQ-032 RESET pulsed between clock edges during grant -> GNT_L=4'b1111 immediately; after release of reset, REQ_L=4'b0101 -> requester 1 granted (PTR=0, 0 not requesting).
